glitch_trig_delay: RTL

Trigger conditioning stage directly upstream of glitch_clk_fast; drives its trig input.
- Synchronises an asynchronous external trigger from the target and detects its rising edge.
- Waits a programmable number of clk cycles, then emits one clean trig pulse of programmable length.
- Enters a holdoff, then disarms.
- Gives the host one-shot arm/abort control and status.

---
 rtl/glitch_trig_delay.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/glitch_trig_delay.sv
// -----------------------------------------------------------------------------
// glitch_trig_delay
//
// Trigger conditioning stage that drives glitch_clk_fast.trig. It synchronises
// the asynchronous target trigger and detects its rising edge. On an edge seen
// while ARMED it waits a programmable number of clk cycles and then issues one
// registered trig pulse of programmable length. After that it spends HOLDOFF
// cycles in a holdoff state and disarms.
//
// Optional feature macro: GLITCH_TRIG_REARM_EN
//   Defined   : after HOLDOFF the FSM returns to ARMED and reuses the latched
//               delay/length. It keeps re-arming until abort or rst.
//   Undefined : one-shot. The FSM returns to IDLE and needs a fresh arm.
//
// Ports:
//   clk         fast glitch clock (same clock as glitch_clk_fast)
//   rst         synchronous active-high reset
//   ext_trig    asynchronous trigger from the target
//   arm         one-cycle arm request (honoured in IDLE only)
//   abort       cancel any operation; wins over everything except rst
//   delay       cycles from the detected edge to the pulse, sampled on arm
//   pulse_len   trig high time in cycles, sampled on arm (0 acts as 1)
//   trig        registered, glitch-free pulse to glitch_clk_fast.trig
//   armed       high while waiting for an edge
//   busy        high in DELAY, PULSE or HOLDOFF
//   done        one-cycle pulse in the first HOLDOFF cycle
//   fire_count  number of pulses issued, wraps, cleared only by rst
// -----------------------------------------------------------------------------
module glitch_trig_delay #(
  parameter int DELAY_W     = 16,
  parameter int LEN_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_trig,
  input  logic               arm,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay,
  input  logic [LEN_W-1:0]   pulse_len,
  output logic               trig,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [7:0]         fire_count
);

  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_HOLDOFF
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   prev_q;
  logic                   sync_out;
  logic                   settle_full;
  logic                   trig_edge;

  logic [DELAY_W-1:0] delay_q, dcnt_q;
  logic [LEN_W-1:0]   len_q, pcnt_q;
  logic [HW-1:0]      hcnt_q;

  logic trig_d, armed_d, busy_d, done_d;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign settle_full = settle_q[SYNC_STAGES-1];
  assign trig_edge   = sync_out & ~prev_q;

  // State register, synchroniser, edge detect, registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      settle_q   <= '0;
      prev_q     <= 1'b1;
      trig       <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fire_count <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_trig};
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      // The synchroniser comes out of reset full of zeros. Holding "previous"
      // high until it has refilled with real samples stops a trigger that was
      // high through reset from looking like a fresh rising edge.
      prev_q   <= settle_full ? sync_out : 1'b1;
      trig     <= trig_d;
      armed    <= armed_d;
      busy     <= busy_d;
      done     <= done_d;
      if (state_d == S_PULSE && state_q != S_PULSE) begin
        fire_count <= fire_count + 8'd1;
      end
    end
  end

  // Datapath: latched settings and down-counters.
  // NOTE: these registers are deliberately not reset; each one is loaded
  // before any state reads it, so a reset would only add routing.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && state_d == S_ARMED) begin
      delay_q <= delay;
      len_q   <= (pulse_len == '0) ? LEN_W'(1) : pulse_len;
    end
    if (state_d == S_DELAY && state_q != S_DELAY) begin
      dcnt_q <= delay_q;
    end else if (state_q == S_DELAY) begin
      dcnt_q <= dcnt_q - DELAY_W'(1);
    end
    if (state_d == S_PULSE && state_q != S_PULSE) begin
      pcnt_q <= len_q;
    end else if (state_q == S_PULSE) begin
      pcnt_q <= pcnt_q - LEN_W'(1);
    end
    if (state_d == S_HOLDOFF && state_q != S_HOLDOFF) begin
      hcnt_q <= HW'(HOLDOFF);
    end else if (state_q == S_HOLDOFF) begin
      hcnt_q <= hcnt_q - HW'(1);
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (arm) state_d = S_ARMED;
        S_ARMED:   if (trig_edge) state_d = (delay_q == '0) ? S_PULSE : S_DELAY;
        S_DELAY:   if (dcnt_q == DELAY_W'(1)) state_d = S_PULSE;
        S_PULSE:   if (pcnt_q == LEN_W'(1)) state_d = S_HOLDOFF;
        S_HOLDOFF: begin
          if (hcnt_q == HW'(1)) begin
`ifdef GLITCH_TRIG_REARM_EN
            state_d = S_ARMED;
`else
            state_d = S_IDLE;
`endif
          end
        end
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state. The results are registered above, so
  // trig comes straight from a flop and cannot glitch.
  always_comb begin
    trig_d  = (state_d == S_PULSE);
    armed_d = (state_d == S_ARMED);
    busy_d  = (state_d inside {S_DELAY, S_PULSE, S_HOLDOFF});
    done_d  = (state_d == S_HOLDOFF) && (state_q != S_HOLDOFF);
  end

endmodule
